// File: rtl/tholin_xbus_ctrl.sv
// rtl/tholin_xbus_ctrl.sv - two-port round-robin sequencer for a multiplexed 16-bit latched-address bus
// Every bus pin is a flop; outputs for a state are loaded on the edge that enters it.
module tholin_xbus_ctrl #(
  parameter int WAIT_STATES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  req_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [1:0]  we_i,
  input  logic [3:0]  be0_i,
  input  logic [3:0]  be1_i,
  input  logic [31:0] wdata1_i,
  output logic [1:0]  ack_o,
  output logic [31:0] rdata_o,
  output logic [15:0] bus_out,
  input  logic [15:0] bus_in,
  output logic        le_lo,
  output logic        le_hi,
  output logic        bus_dir,
  output logic        OEb,
  output logic        WEb_lo,
  output logic        WEb_hi
);

  typedef enum logic [2:0] {
    IDLE, ALH, ALL, RD, WR, HOLD, TURN, DONE
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t      state;
  logic        last_grant;
  logic        grant_q;
  logic [31:2] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        half_q;
  logic        h1_q;
  logic [2:0]  cnt;
  logic [15:0] hi_reg;
  logic        hi_valid;

  logic        pick;
  logic [31:0] sel_addr;
  logic [3:0]  sel_be;
  logic        sel_h0;
  logic        sel_h1;
  logic        sel_hit;
  logic        unused_ok;

  // Address bits [1:0] and port 0's write enable have no effect on the bus.
  assign unused_ok = ^{addr0_i[1:0], addr1_i[1:0], we_i[0]};

  always_comb begin
    pick = req_i[1];
    if (req_i == 2'b11) pick = ~last_grant;
  end

  assign sel_addr = pick ? addr1_i : addr0_i;
  assign sel_be   = pick ? be1_i : be0_i;
  assign sel_h0   = |sel_be[1:0];
  assign sel_h1   = |sel_be[3:2];
  assign sel_hit  = hi_valid && (sel_addr[31:16] == hi_reg);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      bus_out    <= 16'h0000;
      le_lo      <= 1'b0;
      le_hi      <= 1'b0;
      bus_dir    <= 1'b1;
      OEb        <= 1'b1;
      WEb_lo     <= 1'b1;
      WEb_hi     <= 1'b1;
      ack_o      <= 2'b00;
      rdata_o    <= 32'h0000_0000;
      hi_valid   <= 1'b0;
      hi_reg     <= 16'h0000;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0000_0000;
      we_q       <= 1'b0;
      half_q     <= 1'b0;
      h1_q       <= 1'b0;
      cnt        <= 3'd0;
    end else begin
      le_lo   <= 1'b0;
      le_hi   <= 1'b0;
      bus_dir <= 1'b1;
      OEb     <= 1'b1;
      WEb_lo  <= 1'b1;
      WEb_hi  <= 1'b1;
      ack_o   <= 2'b00;
      case (state)
        IDLE: begin
          if (|req_i) begin
            grant_q    <= pick;
            last_grant <= pick;
            addr_q     <= sel_addr[31:2];
            be_q       <= sel_be;
            wdata_q    <= wdata1_i;
            we_q       <= pick & we_i[1];
            half_q     <= ~sel_h0;
            h1_q       <= sel_h1;
            rdata_o    <= 32'h0000_0000;
            if (!sel_h0 && !sel_h1) begin
              state <= DONE;
              ack_o <= pick ? 2'b10 : 2'b01;
            end else if (!sel_hit) begin
              state   <= ALH;
              bus_dir <= 1'b0;
              bus_out <= sel_addr[31:16];
              le_hi   <= 1'b1;
            end else begin
              state   <= ALL;
              bus_dir <= 1'b0;
              bus_out <= {sel_addr[15:2], ~sel_h0, 1'b0};
              le_lo   <= 1'b1;
            end
          end
        end
        ALH: begin
          hi_reg   <= addr_q[31:16];
          hi_valid <= 1'b1;
          state    <= ALL;
          bus_dir  <= 1'b0;
          bus_out  <= {addr_q[15:2], half_q, 1'b0};
          le_lo    <= 1'b1;
        end
        ALL: begin
          cnt <= 3'd0;
          if (we_q) begin
            state   <= WR;
            bus_dir <= 1'b0;
            bus_out <= half_q ? wdata_q[31:16] : wdata_q[15:0];
            WEb_lo  <= ~(half_q ? be_q[2] : be_q[0]);
            WEb_hi  <= ~(half_q ? be_q[3] : be_q[1]);
          end else begin
            state <= RD;
            OEb   <= 1'b0;
          end
        end
        RD: begin
          if (cnt == WS) begin
            if (half_q) rdata_o[31:16] <= bus_in;
            else        rdata_o[15:0]  <= bus_in;
            state <= TURN;
          end else begin
            cnt <= cnt + 3'd1;
            OEb <= 1'b0;
          end
        end
        WR: begin
          bus_dir <= 1'b0;
          if (cnt == WS) begin
            state <= HOLD;
          end else begin
            cnt    <= cnt + 3'd1;
            WEb_lo <= ~(half_q ? be_q[2] : be_q[0]);
            WEb_hi <= ~(half_q ? be_q[3] : be_q[1]);
          end
        end
        HOLD, TURN: begin
          if (!half_q && h1_q) begin
            half_q  <= 1'b1;
            state   <= ALL;
            bus_dir <= 1'b0;
            bus_out <= {addr_q[15:2], 2'b10};
            le_lo   <= 1'b1;
          end else begin
            state <= DONE;
            ack_o <= grant_q ? 2'b10 : 2'b01;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tholin_xbus_ctrl.sv
// tb/tb_tholin_xbus_ctrl.sv - directed self-checking bench for tholin_xbus_ctrl
// Expected values are hand-computed for WAIT_STATES=1.
module tb_tholin_xbus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [1:0]  we = 2'b00;
  logic [3:0]  be0 = 4'h0, be1 = 4'h0;
  logic [31:0] wdata1 = '0;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic [15:0] bus_out;
  logic [15:0] bus_in = 16'h0000;
  logic        le_lo, le_hi, bus_dir, OEb, WEb_lo, WEb_hi;

  int n_checks = 0;
  int n_fail = 0;

  tholin_xbus_ctrl #(.WAIT_STATES(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req),
    .addr0_i(addr0), .addr1_i(addr1), .we_i(we),
    .be0_i(be0), .be1_i(be1), .wdata1_i(wdata1),
    .ack_o(ack), .rdata_o(rdata), .bus_out(bus_out), .bus_in(bus_in),
    .le_lo(le_lo), .le_hi(le_hi), .bus_dir(bus_dir), .OEb(OEb),
    .WEb_lo(WEb_lo), .WEb_hi(WEb_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: data depends on the low address latched by le_lo.
  logic [15:0] lo_addr = 16'h0000;
  always @(negedge clk) begin
    if (le_lo) begin
      lo_addr = bus_out;
      case (bus_out)
        16'h2340: bus_in = 16'hBEEF;
        16'h2342: bus_in = 16'hCAFE;
        default:  bus_in = bus_out ^ 16'h5A5A;
      endcase
    end
  end

  // Bus-protocol invariants, watched on every cycle.
  int viol_excl = 0;
  int viol_turn = 0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if ((int'(le_lo) + int'(le_hi) + int'(!OEb) + int'(!WEb_lo || !WEb_hi)) > 1) viol_excl++;
    if (prev_rd && !bus_dir) viol_turn++;
    prev_rd = !OEb;
  end

  int n_alh, n_all, n_rd, n_wr, n_drive, ack_cyc;
  logic [15:0] alh_val, all_a0, all_a1, wr_val;
  logic wr_lo, wr_hi;
  logic [1:0] ack_val;
  logic [31:0] rd_val;

  task automatic do_xfer(input int p, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] wd);
    @(negedge clk);
    n_alh = 0; n_all = 0; n_rd = 0; n_wr = 0; n_drive = 0; ack_cyc = -1;
    alh_val = '0; all_a0 = '0; all_a1 = '0; wr_val = '0; wr_lo = 1'b1; wr_hi = 1'b1;
    ack_val = '0; rd_val = '0;
    if (p == 0) begin addr0 = a; be0 = b; we = {1'b0, w}; req = 2'b01; end
    else begin addr1 = a; be1 = b; we = {w, 1'b0}; wdata1 = wd; req = 2'b10; end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (le_hi) begin n_alh++; alh_val = bus_out; end
      if (le_lo) begin
        if (n_all == 0) all_a0 = bus_out; else all_a1 = bus_out;
        n_all++;
      end
      if (!OEb) n_rd++;
      if (!bus_dir) n_drive++;
      if (!WEb_lo || !WEb_hi) begin n_wr++; wr_val = bus_out; wr_lo = WEb_lo; wr_hi = WEb_hi; end
      if (ack != 2'b00) begin
        ack_cyc = k; ack_val = ack; rd_val = rdata; req = 2'b00;
        break;
      end
    end
    req = 2'b00;
    if (ack_cyc < 0) check("ack_timeout", 64'd0, 64'd1);
  endtask

  int ord_n, t_ack[3], wcnt;
  logic [1:0] ord[3];
  int post_ack;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_pins", {bus_out, le_lo, le_hi, bus_dir, OEb, WEb_lo, WEb_hi, ack},
          {16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00});
    check("reset_rdata", rdata, 32'h0);

    // Cold-cache word read
    do_xfer(0, 32'h0001_2340, 1'b0, 4'b1111, 32'h0);
    check("t1_alh", {n_alh, 16'h0, alh_val}, {32'd1, 16'h0, 16'h0001});
    check("t1_all", {n_all, all_a0, all_a1}, {32'd2, 16'h2340, 16'h2342});
    check("t1_rd_cycles", n_rd, 4);
    check("t1_ack", {ack_cyc, 30'h0, ack_val}, {32'd10, 30'h0, 2'b01});
    check("t1_rdata", rd_val, 32'hCAFE_BEEF);

    // Single-byte write to upper half, page hit
    do_xfer(1, 32'h0001_2344, 1'b1, 4'b0100, 32'h1122_3344);
    check("t2_no_alh", n_alh, 0);
    check("t2_all", {n_all, all_a0}, {32'd1, 16'h2346});
    check("t2_wr", {n_wr, wr_val, 14'h0, wr_lo, wr_hi}, {32'd2, 16'h1122, 14'h0, 1'b0, 1'b1});
    check("t2_rd_none", n_rd, 0);
    check("t2_ack", {ack_cyc, 30'h0, ack_val}, {32'd5, 30'h0, 2'b10});

    // No bytes enabled
    do_xfer(1, 32'h0009_0000, 1'b0, 4'b0000, 32'h0);
    check("t4_ack", {ack_cyc, 30'h0, ack_val}, {32'd1, 30'h0, 2'b10});
    check("t4_quiet", {n_alh, n_all, n_rd, n_wr, n_drive}, 160'h0);
    check("t4_rdata", rd_val, 32'h0);

    // Page change re-issues high latch
    do_xfer(0, 32'h0002_0000, 1'b0, 4'b1111, 32'h0);
    check("t5_alh", {n_alh, 16'h0, alh_val}, {32'd1, 16'h0, 16'h0002});
    check("t5_rdata", rd_val, 32'h5A58_5A5A);
    check("t5_ack", ack_cyc, 10);

    // Page-hit word read latency
    do_xfer(0, 32'h0002_0004, 1'b0, 4'b1111, 32'h0);
    check("hit_ack", {ack_cyc, n_alh}, {32'd9, 32'd0});
    check("hit_rdata", rd_val, 32'h5A5C_5A5E);

    // Port 0 write is performed as a read, low half only
    do_xfer(0, 32'h0002_0008, 1'b1, 4'b0011, 32'h0);
    check("p0we_as_read", {n_wr, n_rd, ack_cyc}, {32'd0, 32'd2, 32'd5});
    check("p0we_rdata", rd_val, 32'h0000_5A52);

    // Reset asserted during the second write-strobe cycle
    @(negedge clk);
    addr1 = 32'h0002_0000; be1 = 4'b1111; we = 2'b10; wdata1 = 32'hA5A5_5A5A; req = 2'b10;
    wcnt = 0;
    for (int k = 0; k < 20 && wcnt < 2; k++) begin
      @(negedge clk);
      if (!WEb_lo) wcnt++;
    end
    check("t6_reached_wr2", wcnt, 2);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    check("t6_reset_pins", {WEb_lo, WEb_hi, OEb, bus_dir, le_lo, le_hi, ack},
          {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00});
    rst = 1'b0;
    post_ack = 0;
    repeat (5) begin @(negedge clk); if (ack != 2'b00) post_ack++; end
    check("t6_no_ack", post_ack, 0);
    do_xfer(0, 32'h0002_0000, 1'b0, 4'b0001, 32'h0);
    check("t6_alh_again", {n_alh, ack_cyc}, {32'd1, 32'd6});

    // Both ports requesting continuously from reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    addr0 = 32'h0003_0000; addr1 = 32'h0003_0010; be0 = 4'b1111; be1 = 4'b1111; we = 2'b00;
    req = 2'b11;
    ord_n = 0;
    for (int k = 1; k <= 80 && ord_n < 3; k++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        ord[ord_n] = ack; t_ack[ord_n] = k; ord_n++;
        if (ord_n == 3) req = 2'b00;
      end
    end
    req = 2'b00;
    check("t3_count", ord_n, 3);
    check("t3_order", {ord[0], ord[1], ord[2]}, {2'b01, 2'b10, 2'b01});
    check("t3_gaps", {t_ack[1] - t_ack[0], t_ack[2] - t_ack[1]}, {32'd10, 32'd10});

    check("excl_strobes", viol_excl, 0);
    check("no_drive_after_rd", viol_turn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
